// File: rtl/dec_instr_gen.sv
// Instruction-stream generator: issues a programmed number of test encodings over valid/ready,
// chosen by a sequential walk or a 16-bit Galois LFSR, counting issued and illegal words.
module dec_instr_gen #(
  parameter int          CNT_W    = 16,
  parameter logic [15:0] DEF_SEED = 16'hACE1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic [CNT_W-1:0] seed_i,
  input  logic             abort_i,
  output logic             instr_valid_o,
  input  logic             instr_ready_i,
  output logic [31:0]      instr_rdata_o,
  output logic [3:0]       instr_idx_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] issued_cnt_o,
  output logic [CNT_W-1:0] illegal_cnt_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t           state_q;
  logic             mode_q;
  logic [CNT_W-1:0] count_q;
  logic [15:0]      lfsr_q;
  logic [3:0]       idx_q;
  logic [31:0]      rdata_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] issued_q;
  logic [CNT_W-1:0] illegal_q;

  logic [15:0]      seed_eff;
  logic [15:0]      lfsr_d;
  logic [3:0]       first_idx;
  logic [3:0]       idx_d;
  logic [CNT_W-1:0] issued_d;
  logic             hs;

  function automatic logic [31:0] enc_word(input logic [3:0] idx);
    case (idx)
      4'd0:    enc_word = 32'h0FFFFFFF;
      4'd1:    enc_word = 32'h0D90006F;
      4'd2:    enc_word = 32'h06000063;
      4'd3:    enc_word = 32'h10500073;
      4'd4:    enc_word = 32'h00000073;
      4'd5:    enc_word = 32'h00100073;
      4'd6:    enc_word = 32'h7B200073;
      4'd7:    enc_word = 32'h30200073;
      4'd8:    enc_word = 32'h00018023;
      4'd9:    enc_word = 32'h00307037;
      4'd10:   enc_word = 32'hE000C113;
      4'd11:   enc_word = 32'hFFFFFFE3;
      default: enc_word = 32'h0;
    endcase
  endfunction

  // Low nibble folded into 0..11 (values 12..15 alias onto 0..3).
  function automatic logic [3:0] lfsr_idx(input logic [15:0] l);
    lfsr_idx = (l[3:0] >= 4'd12) ? (l[3:0] - 4'd12) : l[3:0];
  endfunction

  always_comb begin
    seed_eff  = (16'(seed_i) == 16'h0) ? DEF_SEED : 16'(seed_i);
    first_idx = mode_i ? lfsr_idx(seed_eff) : 4'd0;
    lfsr_d    = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
    if (mode_q) begin
      idx_d = lfsr_idx(lfsr_d);
    end else begin
      idx_d = (idx_q == 4'd11) ? 4'd0 : idx_q + 4'd1;
    end
    issued_d = issued_q + CNT_W'(1);
    hs       = valid_q && instr_ready_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      count_q   <= '0;
      lfsr_q    <= DEF_SEED;
      idx_q     <= 4'd0;
      rdata_q   <= 32'h0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      issued_q  <= '0;
      illegal_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            mode_q    <= mode_i;
            count_q   <= count_i;
            issued_q  <= '0;
            illegal_q <= '0;
            if (count_i != '0) begin
              lfsr_q  <= seed_eff;
              idx_q   <= first_idx;
              rdata_q <= enc_word(first_idx);
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= ISSUE;
            end else begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        ISSUE: begin
          // Abort wins over a coincident handshake so the counters stay put.
          if (abort_i) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (hs) begin
            issued_q <= issued_d;
            if (idx_q == 4'd0) begin
              illegal_q <= illegal_q + CNT_W'(1);
            end
            if (mode_q) begin
              lfsr_q <= lfsr_d;
            end
            idx_q   <= idx_d;
            rdata_q <= enc_word(idx_d);
            if (issued_d == count_q) begin
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign instr_valid_o = valid_q;
  assign instr_rdata_o = rdata_q;
  assign instr_idx_o   = idx_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign issued_cnt_o  = issued_q;
  assign illegal_cnt_o = illegal_q;

endmodule

// File: tb/tb_dec_instr_gen.sv
// Directed bench for dec_instr_gen: expected words queued at start, checked on each handshake.
module tb_dec_instr_gen;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic        mode_i = 1'b0;
  logic [15:0] count_i = 16'd0;
  logic [15:0] seed_i = 16'd0;
  logic        abort_i = 1'b0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_rdata_o;
  logic [3:0]  instr_idx_o;
  logic        busy_o;
  logic        done_o;
  logic [15:0] issued_cnt_o;
  logic [15:0] illegal_cnt_o;

  dec_instr_gen #(.CNT_W(16), .DEF_SEED(16'hACE1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
    .count_i(count_i), .seed_i(seed_i), .abort_i(abort_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_rdata_o(instr_rdata_o), .instr_idx_o(instr_idx_o),
    .busy_o(busy_o), .done_o(done_o),
    .issued_cnt_o(issued_cnt_o), .illegal_cnt_o(illegal_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;
  int done_seen = 0;
  int exp_illegal = 0;
  logic [31:0] exp_word_q[$];
  logic [3:0]  exp_idx_q[$];
  logic [31:0] words [12] = '{32'h0FFFFFFF, 32'h0D90006F, 32'h06000063, 32'h10500073,
                              32'h00000073, 32'h00100073, 32'h7B200073, 32'h30200073,
                              32'h00018023, 32'h00307037, 32'hE000C113, 32'hFFFFFFE3};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model of the expected stream, pushed when a run is started.
  task automatic push_run(input logic mode, input int count, input logic [15:0] seed);
    logic [15:0] l;
    int s;
    int idx;
    l = (seed == 16'h0) ? 16'hACE1 : seed;
    s = 0;
    exp_illegal = 0;
    for (int i = 0; i < count; i++) begin
      idx = mode ? (int'(l[3:0]) % 12) : s;
      exp_word_q.push_back(words[idx]);
      exp_idx_q.push_back(4'(idx));
      if (idx == 0) exp_illegal++;
      s = (s + 1) % 12;
      if (l[0]) l = (l >> 1) ^ 16'hB400;
      else      l = l >> 1;
    end
  endtask

  task automatic start_run(input logic mode, input int count, input logic [15:0] seed);
    @(negedge clk_i);
    start_i = 1'b1; mode_i = mode; count_i = 16'(count); seed_i = seed;
    push_run(mode, count, seed);
  endtask

  // One cycle: drive ready/abort at the falling edge and score the handshake the next rising edge takes.
  task automatic step(input logic rdy, input logic ab);
    @(negedge clk_i);
    start_i = 1'b0; abort_i = ab; instr_ready_i = rdy;
    if (done_o) done_seen++;
    if (instr_valid_o && rdy && !ab) begin
      if (exp_word_q.size() == 0) begin
        chk("unexpected_word", instr_rdata_o, 32'hDEADBEEF);
      end else begin
        chk("word", instr_rdata_o, exp_word_q.pop_front());
        chk("idx", 32'(instr_idx_o), 32'(exp_idx_q.pop_front()));
      end
    end
  endtask

  task automatic run_to_done(input int budget);
    int n;
    n = 0;
    done_seen = 0;
    while (done_seen == 0 && n < budget) begin
      step(1'b1, 1'b0);
      n++;
    end
    chk("done_within_budget", 32'(done_seen), 32'd1);
  endtask

  initial begin
    #1 rst_i = 1'b1;
    #2;
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_rdata", instr_rdata_o, 32'h0);
    chk("rst_idx", 32'(instr_idx_o), 32'd0);
    chk("rst_busy_done", {30'd0, busy_o, done_o}, 32'd0);
    chk("rst_counters", {issued_cnt_o, illegal_cnt_o}, 32'd0);
    @(negedge clk_i); rst_i = 1'b0;

    // Sequential, count=3, ready high: three back-to-back words then done.
    start_run(1'b0, 3, 16'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      chk("seq3_valid", 32'(instr_valid_o), 32'd1);
    end
    step(1'b1, 1'b0);
    chk("seq3_done", 32'(done_o), 32'd1);
    chk("seq3_valid_off", {30'd0, instr_valid_o, busy_o}, 32'd0);
    chk("seq3_issued", 32'(issued_cnt_o), 32'd3);
    chk("seq3_illegal", 32'(illegal_cnt_o), 32'd1);
    step(1'b0, 1'b0);
    chk("seq3_done_pulse", 32'(done_o), 32'd0);
    chk("seq3_hold_issued", 32'(issued_cnt_o), 32'd3);

    // Backpressure, count=2: word held for four stalled cycles.
    start_run(1'b0, 2, 16'h0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0);
      chk("bp_valid", 32'(instr_valid_o), 32'd1);
      chk("bp_word", instr_rdata_o, 32'h0FFFFFFF);
      chk("bp_issued", 32'(issued_cnt_o), 32'd0);
    end
    run_to_done(10);
    chk("bp_issued_end", 32'(issued_cnt_o), 32'd2);

    // Wrap, count=14.
    start_run(1'b0, 14, 16'h0);
    run_to_done(30);
    chk("wrap_issued", 32'(issued_cnt_o), 32'd14);
    chk("wrap_illegal", 32'(illegal_cnt_o), 32'd2);
    chk("wrap_queue_empty", 32'(exp_word_q.size()), 32'd0);
    step(1'b1, 1'b0);

    // Random, seed 0 -> 0xACE1: index 1 then index 0.
    start_run(1'b1, 2, 16'h0);
    step(1'b0, 1'b0);
    chk("rnd0_first_word", instr_rdata_o, 32'h0D90006F);
    run_to_done(10);
    chk("rnd0_illegal", 32'(illegal_cnt_o), 32'd1);
    step(1'b1, 1'b0);

    // Random with a non-zero seed, longer run.
    start_run(1'b1, 9, 16'h1234);
    run_to_done(20);
    chk("rnd_issued", 32'(issued_cnt_o), 32'd9);
    chk("rnd_illegal", 32'(illegal_cnt_o), 32'(exp_illegal));
    step(1'b1, 1'b0);

    // count=0: no word, done next cycle, counters cleared.
    start_run(1'b0, 0, 16'h0);
    step(1'b1, 1'b0);
    chk("zero_valid", 32'(instr_valid_o), 32'd0);
    chk("zero_done", 32'(done_o), 32'd1);
    chk("zero_counters", {issued_cnt_o, illegal_cnt_o}, 32'd0);
    step(1'b1, 1'b0);
    chk("zero_done_pulse", 32'(done_o), 32'd0);

    // Abort after one of five handshakes.
    start_run(1'b0, 5, 16'h0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    chk("abort_valid_before", 32'(instr_valid_o), 32'd1);
    done_seen = 0;
    step(1'b0, 1'b0);
    chk("abort_valid_after", {30'd0, instr_valid_o, busy_o}, 32'd0);
    chk("abort_issued", 32'(issued_cnt_o), 32'd1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("abort_no_done", 32'(done_seen), 32'd0);
    exp_word_q.delete();
    exp_idx_q.delete();

    // Asynchronous reset mid-run.
    start_run(1'b0, 5, 16'h0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    #2 rst_i = 1'b1;
    #1;
    chk("mrst_valid", 32'(instr_valid_o), 32'd0);
    chk("mrst_rdata", instr_rdata_o, 32'h0);
    chk("mrst_idx_busy", {27'd0, instr_idx_o, busy_o}, 32'd0);
    chk("mrst_counters", {issued_cnt_o, illegal_cnt_o}, 32'd0);
    exp_word_q.delete();
    exp_idx_q.delete();
    @(negedge clk_i); rst_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
